// File: rtl/uart_pkt_pkg.sv
// Shared types and constants for the UART packet decoder.
package uart_pkt_pkg;

  typedef enum logic [2:0] {
    StHunt    = 3'd0,
    StLen     = 3'd1,
    StPayload = 3'd2,
    StChk     = 3'd3,
    StDrain   = 3'd4
  } state_e;

  localparam logic [7:0] DefaultSof = 8'hA5;

  // Address width for a register file of the given depth (at least 1 bit).
  function automatic int unsigned addr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/uart_pkt_decoder_if.sv
// Byte-in / payload-out bundle of the UART packet decoder.
// master: the decoder; slave: the UART receiver plus payload consumer side.
interface uart_pkt_decoder_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_perr;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       m_last;
  logic       pkt_err;
  logic       busy;

  modport master (
    input  rx_data, rx_valid, rx_perr, m_ready,
    output m_data, m_valid, m_last, pkt_err, busy
  );

  modport slave (
    output rx_data, rx_valid, rx_perr, m_ready,
    input  m_data, m_valid, m_last, pkt_err, busy
  );
endinterface

// File: rtl/uart_pkt_buf.sv
// Payload buffer: MAX_LEN x 8 register file, synchronous write, asynchronous read.
module uart_pkt_buf
  import uart_pkt_pkg::*;
#(
  parameter int unsigned MAX_LEN = 16
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [addr_w(MAX_LEN)-1:0]    waddr,
  input  logic [7:0]                    wdata,
  input  logic [addr_w(MAX_LEN)-1:0]    raddr,
  output logic [7:0]                    rdata
);

  logic [7:0] mem [MAX_LEN];

  // Write port; contents are never reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_pkt_decoder.sv
// UART packet decoder: parses SOF, LEN, payload, CHK frames and streams the payload
// out once the checksum has been verified.
// Optional build macro UART_PKT_TIMEOUT_EN adds an inter-byte timeout of
// TIMEOUT_CYCLES clocks while a frame is being received.
module uart_pkt_decoder
  import uart_pkt_pkg::*;
#(
  parameter int unsigned MAX_LEN        = 16,
  parameter logic [7:0]  SOF            = DefaultSof,
  parameter int unsigned TIMEOUT_CYCLES = 10000
) (
  input logic               clk,
  input logic               rst,
  uart_pkt_decoder_if.master bus
);

  localparam int unsigned CW = $clog2(MAX_LEN + 1);
  localparam int unsigned IW = addr_w(MAX_LEN);

  if (MAX_LEN < 1 || MAX_LEN > 255 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("uart_pkt_decoder: illegal parameter value");
  end

  state_e        state_q, state_d;
  logic [CW-1:0] len_q, len_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [CW-1:0] rd_q, rd_d;
  logic [7:0]    sum_q, sum_d;
  logic          err_q, err_d;
  logic          wr_en;
  logic [7:0]    rd_data;
  logic [7:0]    chk_sum;
  logic          m_valid;
  logic          m_last;
  logic          tmo_hit;

`ifdef UART_PKT_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0] tmo_q, tmo_d;
  logic          rx_phase;

  assign rx_phase = (state_q == StLen) || (state_q == StPayload) || (state_q == StChk);
  // A byte arriving on the deadline cycle wins over the timeout.
  assign tmo_hit  = rx_phase && !bus.rx_valid && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  // Idle counter: cleared by every byte and outside the receive phase.
  always_comb begin
    tmo_d = '0;
    if (rx_phase && !bus.rx_valid) tmo_d = tmo_q + TW'(1);
  end

  // Timeout counter register.
  always_ff @(posedge clk) begin
    if (!rst) tmo_q <= '0;
    else      tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  assign chk_sum = sum_q + bus.rx_data;
  assign m_valid = rst && (state_q == StDrain);
  assign m_last  = m_valid && (rd_q == len_q - CW'(1));

  // Frame parser and drain sequencing.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    rd_d    = rd_q;
    sum_d   = sum_q;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    unique case (state_q)
      StHunt: begin
        if (bus.rx_valid && !bus.rx_perr && (bus.rx_data == SOF)) state_d = StLen;
      end
      StLen: begin
        if (bus.rx_valid) begin
          if (bus.rx_perr || (bus.rx_data == 8'd0) || (32'(bus.rx_data) > MAX_LEN)) begin
            err_d   = 1'b1;
            state_d = StHunt;
          end else begin
            len_d   = bus.rx_data[CW-1:0];
            idx_d   = '0;
            sum_d   = '0;
            state_d = StPayload;
          end
        end
      end
      StPayload: begin
        if (bus.rx_valid) begin
          if (bus.rx_perr) begin
            err_d   = 1'b1;
            state_d = StHunt;
          end else begin
            wr_en = 1'b1;
            sum_d = chk_sum;
            idx_d = idx_q + CW'(1);
            if (idx_q == len_q - CW'(1)) state_d = StChk;
          end
        end
      end
      StChk: begin
        if (bus.rx_valid) begin
          if (bus.rx_perr || (chk_sum != 8'd0)) begin
            err_d   = 1'b1;
            state_d = StHunt;
          end else begin
            rd_d    = '0;
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        // Any byte arriving while draining is an overrun, even on the final transfer.
        if (bus.rx_valid) err_d = 1'b1;
        if (bus.m_ready) begin
          rd_d = rd_q + CW'(1);
          if (m_last) state_d = StHunt;
        end
      end
      default: state_d = StHunt;
    endcase
    if (tmo_hit) begin
      err_d   = 1'b1;
      state_d = StHunt;
    end
  end

  // Parser state registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StHunt;
      len_q   <= '0;
      idx_q   <= '0;
      rd_q    <= '0;
      sum_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      rd_q    <= rd_d;
      sum_q   <= sum_d;
      err_q   <= err_d;
    end
  end

  uart_pkt_buf #(
    .MAX_LEN(MAX_LEN)
  ) u_buf (
    .clk  (clk),
    .we   (wr_en),
    .waddr(idx_q[IW-1:0]),
    .wdata(bus.rx_data),
    .raddr(rd_q[IW-1:0]),
    .rdata(rd_data)
  );

  // Outputs are forced low while reset is held.
  assign bus.m_valid = m_valid;
  assign bus.m_last  = m_last;
  assign bus.m_data  = m_valid ? rd_data : 8'h00;
  assign bus.pkt_err = rst && err_q;
  assign bus.busy    = rst && (state_q != StHunt);

endmodule

// File: tb/tb_uart_pkt_decoder.sv
// Self-checking bench for uart_pkt_decoder: directed frames plus randomized frames
// compared against a queue-based frame parser model.
module tb_uart_pkt_decoder;
  import uart_pkt_pkg::*;

  localparam int unsigned MaxLen    = 16;
  localparam logic [7:0]  Sof       = DefaultSof;
  localparam int unsigned TmoCycles = 100;

  logic clk = 1'b0;
  logic rst = 1'b0;

  uart_pkt_decoder_if bus();

  uart_pkt_decoder #(
    .MAX_LEN       (MaxLen),
    .SOF           (Sof),
    .TIMEOUT_CYCLES(TmoCycles)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- monitor ----------------
  logic [8:0] got_q[$];
  int         got_cyc[$];
  int         err_seen = 0;
  logic       stall_q = 1'b0;
  logic [7:0] stall_data = '0;
  logic       stall_last = 1'b0;

  // Collect transfers and error pulses; held outputs must not move during a stall.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.pkt_err) err_seen <= err_seen + 1;
      if (stall_q && bus.m_valid) begin
        check("hold_data", 32'(bus.m_data), 32'(stall_data));
        check("hold_last", 32'(bus.m_last), 32'(stall_last));
      end
      if (bus.m_valid && bus.m_ready) begin
        got_q.push_back({bus.m_last, bus.m_data});
        got_cyc.push_back(cyc);
      end
      stall_q    <= bus.m_valid && !bus.m_ready;
      stall_data <= bus.m_data;
      stall_last <= bus.m_last;
    end else begin
      stall_q <= 1'b0;
    end
  end

  // ---------------- reference model ----------------
  logic [7:0] frm[$];
  logic [8:0] exp_q[$];
  int         exp_err = 0;

  task automatic model_byte(input logic [7:0] d, input bit pe);
    int s;
    if (frm.size() == 0) begin
      if (d == Sof && !pe) frm.push_back(d);
      return;
    end
    if (pe) begin
      exp_err++;
      frm.delete();
      return;
    end
    frm.push_back(d);
    if (frm.size() == 2) begin
      if (d == 8'd0 || int'(d) > int'(MaxLen)) begin
        exp_err++;
        frm.delete();
      end
      return;
    end
    if (frm.size() == int'(frm[1]) + 3) begin
      s = 0;
      for (int i = 2; i < frm.size(); i++) s += int'(frm[i]);
      if (s % 256 == 0) begin
        for (int i = 2; i < frm.size() - 1; i++) exp_q.push_back({i == frm.size() - 2, frm[i]});
      end else begin
        exp_err++;
      end
      frm.delete();
    end
  endtask

  task automatic model_reset();
    frm.delete();
    exp_q.delete();
  endtask

  // ---------------- drivers ----------------
  bit rand_rdy = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) bus.m_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_byte(input logic [7:0] d, input bit pe);
    bus.rx_data  = d;
    bus.rx_perr  = pe;
    bus.rx_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    bus.rx_perr  = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input bit pe);
    drive_byte(d, pe);
    model_byte(d, pe);
  endtask

  // Byte sent while the decoder is draining: always an overrun.
  task automatic send_overrun(input logic [7:0] d);
    drive_byte(d, 1'b0);
    exp_err++;
  endtask

  // Send b[0..] up to pe_pos (inclusive, flagged with parity error) or all if pe_pos < 0.
  task automatic send_seq(input logic [7:0] b[$], input int pe_pos, input int max_gap);
    for (int i = 0; i < b.size(); i++) begin
      send_byte(b[i], i == pe_pos);
      if (i == pe_pos) break;
      if (max_gap > 0) idle($urandom_range(0, max_gap));
    end
  endtask

  task automatic settle(input int budget);
    int n;
    n = 0;
    while (bus.busy && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("settle_busy", 32'(bus.busy), 32'd0);
    idle(2);
    check("err_count", err_seen, exp_err);
    check("n_out", got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      check("out_byte", 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    got_q.delete();
    exp_q.delete();
    got_cyc.delete();
  endtask

  function automatic logic [7:0] chk_of(input logic [7:0] p[$]);
    int s;
    s = 0;
    foreach (p[i]) s += int'(p[i]);
    return 8'((256 - (s % 256)) % 256);
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] seq[$];
    logic [7:0] pay[$];
    int         chk_cyc;
    int         len;
    int         kind;

    bus.rx_data  = '0;
    bus.rx_valid = 1'b0;
    bus.rx_perr  = 1'b0;
    bus.m_ready  = 1'b0;
    rst          = 1'b0;
    idle(3);
    check("rst_busy",    32'(bus.busy),    32'd0);
    check("rst_m_valid", 32'(bus.m_valid), 32'd0);
    check("rst_m_last",  32'(bus.m_last),  32'd0);
    check("rst_pkt_err", 32'(bus.pkt_err), 32'd0);
    check("rst_m_data",  32'(bus.m_data),  32'd0);
    rst = 1'b1;
    idle(2);

    // Basic frame, consumer always ready: bytes on consecutive cycles after CHK.
    bus.m_ready = 1'b1;
    seq = '{8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'hFA};
    send_seq(seq, -1, 0);
    chk_cyc = cyc;
    idle(4);
    check("t1_cnt", got_cyc.size(), 3);
    for (int i = 0; i < got_cyc.size(); i++) check("t1_cyc", got_cyc[i] - chk_cyc, i);
    settle(50);

    // SOF colliding with the final transfer is an overrun, not a new frame.
    send_seq(seq, -1, 0);
    idle(2);
    send_overrun(8'hA5);
    seq = '{8'h01, 8'h7F, 8'h81};
    send_seq(seq, -1, 0);
    settle(50);

    // Bad checksum.
    seq = '{8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'hFB};
    send_seq(seq, -1, 1);
    settle(50);

    // Oversized LEN then a one-byte frame.
    seq = '{8'hA5, 8'h11};
    send_seq(seq, -1, 0);
    settle(50);
    seq = '{8'hA5, 8'h01, 8'h7F, 8'h81};
    send_seq(seq, -1, 0);
    settle(50);

    // Stalled consumer with an overrun byte during DRAIN.
    bus.m_ready = 1'b0;
    seq = '{8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'hFA};
    send_seq(seq, -1, 0);
    idle(5);
    send_overrun(8'h55);
    idle(14);
    check("t4_valid", 32'(bus.m_valid), 32'd1);
    check("t4_hold",  32'(bus.m_data),  32'h01);
    check("t4_none",  got_q.size(),     0);
    bus.m_ready = 1'b1;
    settle(50);

    // Parity error mid-payload, then a clean frame.
    seq = '{8'hA5, 8'h02, 8'h10};
    send_seq(seq, 2, 0);
    settle(50);
    seq = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'hD0};
    send_seq(seq, -1, 0);
    settle(50);

    // Stalled mid-payload: timeout when enabled, otherwise waits; then reset drops it.
    seq = '{8'hA5, 8'h02, 8'h10};
    send_seq(seq, -1, 0);
    idle(150);
`ifdef UART_PKT_TIMEOUT_EN
    exp_err++;
    frm.delete();
`endif
    check("t6_busy", 32'(bus.busy), 32'(frm.size() != 0));
    check("t6_err",  err_seen,      exp_err);
    rst = 1'b0;
    idle(2);
    model_reset();
    rst = 1'b1;
    idle(2);
    settle(10);

    // Reset while draining discards the packet without an error.
    bus.m_ready = 1'b0;
    seq = '{8'hA5, 8'h02, 8'h33, 8'h44, 8'h89};
    send_seq(seq, -1, 0);
    idle(3);
    check("t7_drain", 32'(bus.m_valid), 32'd1);
    rst = 1'b0;
    idle(2);
    model_reset();
    check("t7_rst_valid", 32'(bus.m_valid), 32'd0);
    rst = 1'b1;
    bus.m_ready = 1'b1;
    idle(3);
    settle(10);

    // Randomized frames with random consumer back-pressure.
    rand_rdy = 1'b1;
    for (int f = 0; f < 40; f++) begin
      kind = $urandom_range(0, 5);
      len  = $urandom_range(1, MaxLen);
      pay.delete();
      for (int i = 0; i < len; i++) pay.push_back(8'($urandom_range(0, 255)));
      seq.delete();
      seq.push_back(Sof);
      seq.push_back(8'(len));
      foreach (pay[i]) seq.push_back(pay[i]);
      seq.push_back(chk_of(pay));
      unique case (kind)
        0, 1: send_seq(seq, -1, 2);
        2: begin
          seq[seq.size() - 1] = seq[seq.size() - 1] ^ 8'($urandom_range(1, 255));
          send_seq(seq, -1, 2);
        end
        3: begin
          seq.delete();
          seq.push_back(Sof);
          seq.push_back(($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(MaxLen + 1, 255)));
          send_seq(seq, -1, 2);
        end
        4: send_seq(seq, $urandom_range(1, seq.size() - 1), 2);
        default: begin
          for (int i = 0; i < 6; i++) begin
            seq[0] = 8'($urandom_range(0, 255));
            send_byte(seq[0], seq[0] == Sof);
          end
        end
      endcase
      settle(400);
    end
    rand_rdy = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    $fatal(1, "simulation did not finish");
  end

endmodule

// File: doc/uart_pkt_decoder.md
UART_PKT_DECODER -- requirements
Module: uart_pkt_decoder

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16, maximum payload bytes per packet (legal range 1..255).
REQ-002 SHALL have parameter SOF, default 8'hA5, start-of-frame byte.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 10000, inter-byte timeout in clk cycles.
REQ-004 SHALL have port clk  in  1  clock; all logic on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port rx_data  in  8  byte from UART receiver.
REQ-007 SHALL have port rx_valid  in  1  one-cycle pulse qualifying rx_data.
REQ-008 SHALL have port rx_perr  in  1  parity error for the byte, sampled with rx_valid.
REQ-009 SHALL have port m_data  out  8  payload byte to consumer.
REQ-010 SHALL have port m_valid  out  1  m_data valid.
REQ-011 SHALL have port m_ready  in  1  consumer accepts byte.
REQ-012 SHALL have port m_last  out  1  marks final payload byte; qualified by m_valid.
REQ-013 SHALL have port pkt_err  out  1  one-cycle pulse per dropped packet or discarded byte.
REQ-014 SHALL have port busy  out  1  high in every state except HUNT.

Function
REQ-015 SHALL accept the frame format SOF, LEN, LEN payload bytes, CHK, where (sum of payload + CHK) mod 256 == 0.
REQ-016 SHALL implement states HUNT, LEN, PAYLOAD, CHK and DRAIN.
REQ-017 HUNT: on rx_valid with rx_data==SOF and !rx_perr, go to LEN; ignore all other bytes without pkt_err.
REQ-018 LEN: if LEN==0 or LEN>MAX_LEN, pulse pkt_err and go to HUNT; otherwise latch LEN, clear index and 8-bit sum, go to PAYLOAD.
REQ-019 PAYLOAD: write each byte to buffer[index], sum += byte mod 256, index++; after byte LEN-1, go to CHK.
REQ-020 CHK: if (sum+CHK) mod 256 == 0, go to DRAIN; otherwise pulse pkt_err and go to HUNT.
REQ-021 In LEN, PAYLOAD or CHK, any rx_valid with rx_perr=1 SHALL pulse pkt_err and go to HUNT; that byte is not used.
REQ-022 DRAIN: m_valid=1 from the cycle after the CHK byte is sampled; m_data=buffer[rd]; m_last=1 when rd==LEN-1.
REQ-023 Transfer occurs when m_valid && m_ready; rd increments by 1; after the m_last transfer, m_valid=0 on the next cycle and state returns to HUNT.
REQ-024 m_data and m_last SHALL remain stable while m_valid && !m_ready.
REQ-025 An rx_valid arriving in DRAIN SHALL be discarded and pulse pkt_err (overrun), with no state change.
REQ-026 When rx_valid and the final m_last transfer occur in the same cycle, the byte is discarded with pkt_err; it is not treated as a SOF.
REQ-027 Index, rd and length counters SHALL be $clog2(MAX_LEN+1) bits wide; sum SHALL be 8 bits and wrap.

Reset
REQ-028 While rst==0: state=HUNT; m_valid, m_last, pkt_err and busy =0; m_data=0; counters and sum =0.
REQ-029 A reset asserted mid-packet or mid-DRAIN SHALL discard the packet without a pkt_err pulse; buffer contents need not be cleared.

Configuration
REQ-030 With UART_PKT_TIMEOUT_EN defined: a counter clears on every rx_valid and counts only in LEN, PAYLOAD and CHK; on reaching TIMEOUT_CYCLES-1 the block pulses pkt_err and goes to HUNT.
REQ-031 Without UART_PKT_TIMEOUT_EN: no timeout counter is present, and the block waits in LEN, PAYLOAD or CHK indefinitely.

Structure
REQ-032 Package uart_pkt_pkg SHALL hold the state encoding constants and the default SOF value.
REQ-033 Sub-module uart_pkt_buf SHALL be a MAX_LEN x 8 register file with one synchronous write port and one asynchronous read port.

Verification
REQ-034 Send A5 03 01 02 03 FA with m_ready=1 -> m_data 01,02,03 on consecutive cycles, m_last on 03, no pkt_err.
REQ-035 Send A5 03 01 02 03 FB -> single pkt_err pulse, m_valid never asserted, busy low after CHK.
REQ-036 Send A5 11 with MAX_LEN=16 -> pkt_err after LEN; then A5 01 7F 81 -> one byte 7F with m_last.
REQ-037 Send a valid packet with m_ready=0 for 20 cycles and a byte arriving during DRAIN -> m_data holds 01, pkt_err pulses once, and all 3 bytes are delivered after m_ready=1.
REQ-038 Send A5 02 10 with rx_perr=1 on 10 -> pkt_err pulse, return to HUNT; next packet decodes normally.
REQ-039 With UART_PKT_TIMEOUT_EN, TIMEOUT_CYCLES=100: send A5 02 10 then idle for 150 cycles -> pkt_err at cycle 100 after 10; without the macro, state stays PAYLOAD.
